// File: rtl/reg_sb_pkg.sv
// Shared defaults and types for the register scoreboard.
package reg_sb_pkg;

    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_NUM_SRC  = 2;
    localparam int DEF_CNT_W    = 3;
    localparam int DEF_REG_W    = $clog2(DEF_NUM_REGS);

    typedef logic [DEF_REG_W-1:0] reg_idx_t;
    typedef logic [DEF_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/reg_sb_counter.sv
// Per-register saturating pending-writer counter; dec is gated at zero and
// reported as underflow instead.
module reg_sb_counter
    import reg_sb_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             saturated,
    output logic             underflow
);

    logic inc_eff;
    logic dec_eff;

    assign nonzero   = |count;
    assign saturated = &count;
    assign underflow = dec & ~nonzero;
    assign inc_eff   = inc & ~saturated;
    assign dec_eff   = dec & nonzero;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count <= '0;
        end else if (inc_eff && !dec_eff) begin
            count <= count + 1'b1;
        end else if (dec_eff && !inc_eff) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard at decode: per-register writer counters, source
// dependency stall, full stall and sticky retire-underflow error.
// Optional macro REG_SCOREBOARD_BYPASS_EN: a source resolved by a same-cycle
// retire of its last writer does not stall.
module reg_scoreboard
    import reg_sb_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_SRC  = DEF_NUM_SRC,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int REG_W    = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_v,
    input  logic [NUM_SRC-1:0]       src_v,
    input  logic [NUM_SRC*REG_W-1:0] src_reg,
    input  logic                     dst_v,
    input  logic [REG_W-1:0]         dst_reg,
    input  logic                     retire_v,
    input  logic [REG_W-1:0]         retire_reg,
    input  logic                     flush,
    output logic                     dep,
    output logic                     full,
    output logic                     issue_ok,
    output logic [NUM_REGS-1:0]      busy,
    output logic                     err
);

    localparam int unsigned IDX_SPAN = 2 ** REG_W;

    logic [CNT_W-1:0]    cnt     [NUM_REGS];
    logic [CNT_W-1:0]    cnt_ext [IDX_SPAN];
    logic [IDX_SPAN-1:0] sat_ext;
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;
    logic [NUM_REGS-1:0] nonzero;
    logic [NUM_REGS-1:0] saturated;
    logic [NUM_REGS-1:0] underflow;
    logic                src_hit;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
        assign inc[r] = issue_ok & dst_v & (dst_reg == REG_W'(r));
        // Retires are squashed along with everything else during a flush.
        assign dec[r] = retire_v & ~flush & (retire_reg == REG_W'(r));

        reg_sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc[r]),
            .dec       (dec[r]),
            .flush     (flush),
            .count     (cnt[r]),
            .nonzero   (nonzero[r]),
            .saturated (saturated[r]),
            .underflow (underflow[r])
        );
    end

    // Indices beyond NUM_REGS read as an idle register.
    always_comb begin
        sat_ext = '0;
        for (int unsigned r = 0; r < IDX_SPAN; r++) begin
            cnt_ext[r] = '0;
        end
        for (int unsigned r = 0; r < int'(NUM_REGS); r++) begin
            cnt_ext[r] = cnt[r];
            sat_ext[r] = saturated[r];
        end
    end

    always_comb begin
        src_hit = 1'b0;
        for (int unsigned i = 0; i < int'(NUM_SRC); i++) begin
            logic [REG_W-1:0] idx;
            logic             hit;
            idx = src_reg[i*REG_W +: REG_W];
            hit = src_v[i] & (cnt_ext[idx] != '0);
`ifdef REG_SCOREBOARD_BYPASS_EN
            if (cnt_ext[idx] == CNT_W'(1) && retire_v && !flush && retire_reg == idx) begin
                hit = 1'b0;
            end
`endif
            src_hit = src_hit | hit;
        end
    end

    assign dep      = issue_v & src_hit;
    assign full     = issue_v & dst_v & sat_ext[dst_reg];
    assign issue_ok = issue_v & ~dep & ~full & ~flush;
    assign busy     = nonzero;

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (|underflow) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard with default parameters.
module tb_reg_scoreboard;
    import reg_sb_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_v;
    logic [1:0] src_v;
    logic [5:0] src_reg;
    logic       dst_v;
    reg_idx_t   dst_reg;
    logic       retire_v;
    reg_idx_t   retire_reg;
    logic       flush;
    logic       dep;
    logic       full;
    logic       issue_ok;
    logic [7:0] busy;
    logic       err;

    int errors = 0;
    int checks = 0;

    reg_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .issue_v    (issue_v),
        .src_v      (src_v),
        .src_reg    (src_reg),
        .dst_v      (dst_v),
        .dst_reg    (dst_reg),
        .retire_v   (retire_v),
        .retire_reg (retire_reg),
        .flush      (flush),
        .dep        (dep),
        .full       (full),
        .issue_ok   (issue_ok),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        issue_v    = 1'b0;
        src_v      = '0;
        src_reg    = '0;
        dst_v      = 1'b0;
        dst_reg    = '0;
        retire_v   = 1'b0;
        retire_reg = '0;
        flush      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_dst(input reg_idx_t r);
        issue_v = 1'b1;
        dst_v   = 1'b1;
        dst_reg = r;
    endtask

    task automatic retire(input reg_idx_t r);
        retire_v   = 1'b1;
        retire_reg = r;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'h00);
        check("rst_err", 32'(err), 0);
        check("rst_dep", 32'(dep), 0);
        check("rst_full", 32'(full), 0);
        check("rst_issue_ok", 32'(issue_ok), 0);

        // A: write r3, no sources
        issue_dst(3);
        #1;
        check("a_issue_ok", 32'(issue_ok), 1);
        tick();
        idle();
        #1;
        check("a_busy", 32'(busy), 32'h08);

        // B: reads r3 on source 0
        issue_v = 1'b1;
        src_v   = 2'b01;
        src_reg = {3'd0, 3'd3};
        #1;
        check("b_dep", 32'(dep), 1);
        check("b_issue_ok", 32'(issue_ok), 0);
        retire(3);
        #1;
`ifdef REG_SCOREBOARD_BYPASS_EN
        check("b_dep_retire_cyc", 32'(dep), 0);
`else
        check("b_dep_retire_cyc", 32'(dep), 1);
`endif
        tick();
        retire_v = 1'b0;
        #1;
        check("b_busy_after_ret", 32'(busy), 32'h00);
        check("b_dep_after_ret", 32'(dep), 0);
        check("b_issue_ok_after", 32'(issue_ok), 1);
        idle();

        // Seven writers to r5 saturate the counter
        for (int i = 0; i < 7; i++) begin
            issue_dst(5);
            #1;
            check("r5_fill_ok", 32'(issue_ok), 1);
            tick();
        end
        idle();
        #1;
        check("r5_busy", 32'(busy), 32'h20);
        issue_v = 1'b1;
        src_v   = 2'b10;
        src_reg = {3'd5, 3'd0};
        #1;
        check("r5_dep_src1", 32'(dep), 1);
        idle();
        issue_dst(5);
        #1;
        check("r5_full", 32'(full), 1);
        check("r5_full_issue_ok", 32'(issue_ok), 0);
        retire(5);
        #1;
        check("r5_full_with_ret", 32'(full), 1);
        check("r5_ok_with_ret", 32'(issue_ok), 0);
        tick();
        retire_v = 1'b0;
        #1;
        check("r5_full_at6", 32'(full), 0);
        check("r5_ok_at6", 32'(issue_ok), 1);
        idle();
        // count is now 6: five retires leave it busy, the sixth clears it
        for (int i = 0; i < 6; i++) begin
            retire(5);
            tick();
            idle();
            #1;
            if (i == 4) check("r5_busy_at1", 32'(busy), 32'h20);
            if (i == 5) check("r5_busy_at0", 32'(busy), 32'h00);
        end

        // Issue and retire on r2 together at count 1
        issue_dst(2);
        tick();
        issue_dst(2);
        retire(2);
        #1;
        check("r2_both_ok", 32'(issue_ok), 1);
        tick();
        idle();
        #1;
        check("r2_busy_kept", 32'(busy), 32'h04);
        retire(2);
        tick();
        idle();
        #1;
        check("r2_busy_clear", 32'(busy), 32'h00);

        // Source equal to own destination: no self-dependency
        issue_dst(7);
        src_v   = 2'b01;
        src_reg = {3'd0, 3'd7};
        #1;
        check("self_dep", 32'(dep), 0);
        check("self_ok", 32'(issue_ok), 1);
        tick();
        idle();
        retire(7);
        tick();
        idle();
        #1;
        check("self_clear", 32'(busy), 32'h00);

        // Flush with r1=2, r4=1 and concurrent issue/retire
        issue_dst(1);
        tick();
        tick();
        issue_dst(4);
        tick();
        idle();
        #1;
        check("fl_busy_pre", 32'(busy), 32'h12);
        issue_dst(0);
        retire(1);
        flush = 1'b1;
        #1;
        check("fl_issue_ok", 32'(issue_ok), 0);
        tick();
        idle();
        #1;
        check("fl_busy", 32'(busy), 32'h00);
        check("fl_err", 32'(err), 0);
        // A retire on an empty register is ignored while flushing
        retire(6);
        flush = 1'b1;
        tick();
        idle();
        #1;
        check("fl_ret_zero_err", 32'(err), 0);

        // Retire on empty r6 sets sticky err
        retire(6);
        tick();
        idle();
        #1;
        check("err_set", 32'(err), 1);
        check("err_busy", 32'(busy), 32'h00);
        issue_dst(0);
        tick();
        idle();
        retire(0);
        tick();
        idle();
        #1;
        check("err_held", 32'(err), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("err_reset", 32'(err), 0);

        // Reset wins over a concurrent issue
        issue_dst(1);
        tick();
        idle();
        #1;
        check("rp_busy_pre", 32'(busy), 32'h02);
        reset = 1'b1;
        issue_dst(2);
        retire(6);
        tick();
        reset = 1'b0;
        idle();
        #1;
        check("rp_busy", 32'(busy), 32'h00);
        check("rp_err", 32'(err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Parametrised register scoreboard for the in-order pipeline, placed at decode. It tracks in-flight writes per architectural register with saturating counters instead of comparing against fixed stage tags. Decode sends source and destination register numbers. The block raises a dependency stall while any source has an outstanding writer. It also counts writers in on issue and out on writeback retire, and it clears on pipeline flush.

## Interface
Parameters:
- NUM_REGS, 8, number of architectural registers tracked
- NUM_SRC, 2, source operands checked per instruction
- CNT_W, 3, per-register pending-writer counter width (max 2^CNT_W-1 in flight)
- REG_W, $clog2(NUM_REGS), register index width (derived, not overridden)

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high
- issue_v  in  1  decode holds a valid instruction
- src_v  in  NUM_SRC  per-source valid (e.g. ro needed, rm-is-register)
- src_reg  in  NUM_SRC*REG_W  packed source indices, source i at [i*REG_W +: REG_W]
- dst_v  in  1  instruction writes a register
- dst_reg  in  REG_W  destination index
- retire_v  in  1  writeback stage commits a register write
- retire_reg  in  REG_W  retired destination index
- flush  in  1  pipeline flush; all in-flight writers squashed
- dep  out  1  combinational: some valid source has a pending writer
- full  out  1  combinational: dst counter saturated, issue must stall
- issue_ok  out  1  combinational: instruction accepted this cycle
- busy  out  NUM_REGS  registered: bit r set when count[r] != 0
- err  out  1  registered sticky: retire on zero counter

## Operation
- State: count[r], CNT_W bits each, for r in 0..NUM_REGS-1.
- dep = issue_v & OR over i of (src_v[i] & count[src_reg[i]] != 0).
- full = issue_v & dst_v & (count[dst_reg] == all-ones).
- issue_ok = issue_v & !dep & !full & !flush.
- inc[r] = issue_ok & dst_v & dst_reg==r. dec[r] = retire_v & retire_reg==r & count[r]!=0.
- Next count[r]:
  - inc and dec together: count unchanged.
  - inc only: count+1.
  - dec only: count-1.
  - Neither: count unchanged.
  - Arithmetic is CNT_W bits with no wrap, because full blocks inc at max and dec is gated at zero.
- retire_v on a register whose count is 0: no count change; err sets and holds until reset.
- flush: next count = 0 for all registers. issue_ok is 0 that cycle, and retire_v is ignored that cycle. err is unaffected.
- A source equal to the instruction's own destination is checked against the count before this instruction's increment. There is no self-dependency.
- Out-of-range indices cannot occur when NUM_REGS == 2^REG_W. Otherwise indices >= NUM_REGS read as count 0 and are never written.

## Timing
- Reset values: all count 0, busy 0, err 0. With inputs idle, dep, full and issue_ok are 0.
- dep, full and issue_ok are same-cycle combinational from registered counts and inputs.
- Counter updates are visible one cycle after the inc or retire edge.
- Back-to-back dependent instructions:
  - Instruction A issues writing r in cycle n.
  - Instruction B reading r sees dep=1 from cycle n+1 until the cycle after A's retire. No bypass applies in that cycle (see Configuration).
- Reset mid-operation: all state is cleared on the next edge regardless of other inputs. Reset takes priority over flush, inc and dec.

## Configuration
- REG_SCOREBOARD_BYPASS_EN defined:
  - A source whose count is exactly 1 and which matches retire_reg with retire_v=1 in the same cycle does not raise dep.
  - The writeback value is forwarded by the datapath.
  - This saves one stall cycle per retire-resolved hazard.
  - Bypass never applies during flush.
- Undefined: dep uses registered counts only, as specified in Operation.

## Structure
- Shared package reg_sb_pkg:
  - default NUM_REGS, NUM_SRC and CNT_W constants
  - typedef for the register index
  - typedef for the counter
- One sub-module, reg_sb_counter, instantiated NUM_REGS times via generate.
  - Inputs: inc, dec, flush, reset.
  - Outputs: count, nonzero, saturated, underflow.
- Top level holds the source-compare OR tree, the full/issue_ok logic and the err flop.

## Test plan
- Reset, then issue dst=r3 with src_v=0 → issue_ok=1, next cycle busy=8'b0000_1000. A following instruction with src_reg=3 gets dep=1 and issue_ok=0.
- Retire r3 → busy[3]=0 next cycle and dep drops. With REG_SCOREBOARD_BYPASS_EN, dep=0 already in the retire cycle.
- Issue seven writes to r5 (CNT_W=3) → count=7. The eighth gets full=1 and issue_ok=0. A simultaneous issue and retire on r5 at count 7 still gives full=1 (inc blocked), and count drops to 6.
- Issue r2 and retire r2 in the same cycle at count 1 → count stays 1 and busy[2] stays 1.
- Flush with counts {r1=2, r4=1} plus a concurrent retire_v and issue_v → all counts 0 next cycle, issue_ok=0, err unchanged.
- retire_v on r6 with count 0 → err=1 next cycle and held through later traffic. Reset clears it.
